hazard_ctrl: RTL and testbench

- Pipeline stall/flush controller for the 5-stage RISC-V core.
- The forwarding unit resolves RAW hazards by bypassing in EX. This block handles the hazards it cannot resolve: load-use, taken branches, and multicycle EX ops (mul/div).
- Drives PC/IF-ID write enables and IF/ID, ID/EX flushes, and holds EX during multicycle ops.

---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_perf_cnt.sv | 47 ++++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states,
// register-address width and the NOP encoding used by IF/ID flush consumers.
package hazard_ctrl_pkg;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Pair of saturating event counters: index 0 counts stall cycles,
// index 1 counts taken-branch flushes. Synchronous active-low reset.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [1:0]            inc;
  logic [1:0][CNT_W-1:0] cnt_all;

  assign inc = {flush_inc_i, stall_inc_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Hold at all-ones instead of wrapping.
      always_comb begin
        cnt_d = cnt_q;
        if (inc[gi] && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_all[gi] = cnt_q;
    end
  endgenerate

  assign stall_cnt_o = cnt_all[0];
  assign flush_cnt_o = cnt_all[1];

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use bubbles, taken-branch
// flushes and multicycle EX holds. Define HAZARD_PERF_CNT_EN to add perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] ID_rs1_i,
  input  logic [REG_ADDR_W-1:0] ID_rs2_i,
  input  logic                  ID_use_rs1_i,
  input  logic                  ID_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] EX_rd_i,
  input  logic                  EX_MemRead_i,
  input  logic                  EX_mc_i,
  input  logic                  branch_taken_i,
  output logic                  PCWrite_o,
  output logic                  IFID_Write_o,
  output logic                  IFID_Flush_o,
  output logic                  IDEX_Flush_o,
  output logic                  EX_hold_o,
  output logic                  mc_done_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

  localparam int             CW       = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(MC_LAT - 2);

  hz_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mc_ack_q, mc_ack_d;
  logic          lu;
  logic          taken_flush;

  assign lu = EX_MemRead_i && (EX_rd_i != '0) &&
              (((EX_rd_i == ID_rs1_i) && ID_use_rs1_i) ||
               ((EX_rd_i == ID_rs2_i) && ID_use_rs2_i));

  always_comb begin
    PCWrite_o    = 1'b1;
    IFID_Write_o = 1'b1;
    IFID_Flush_o = 1'b0;
    IDEX_Flush_o = 1'b0;
    EX_hold_o    = 1'b0;
    mc_done_o    = 1'b0;
    taken_flush  = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    mc_ack_d     = 1'b0;

    if (!rst_i) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      IFID_Flush_o = 1'b1;
      IDEX_Flush_o = 1'b1;
      state_d      = RUN;
      cnt_d        = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken_i) begin
            IFID_Flush_o = 1'b1;
            IDEX_Flush_o = 1'b1;
            taken_flush  = 1'b1;
          // mc_ack masks the op that just finished so it is not restarted.
          end else if (EX_mc_i && !mc_ack_q) begin
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
            EX_hold_o    = 1'b1;
            state_d      = MC_WAIT;
            cnt_d        = CNT_INIT;
          end else if (lu) begin
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
            IDEX_Flush_o = 1'b1;
          end
        end
        MC_WAIT: begin
          PCWrite_o    = 1'b0;
          IFID_Write_o = 1'b0;
          EX_hold_o    = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            mc_done_o = 1'b1;
            state_d   = RUN;
            mc_ack_d  = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      mc_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mc_ack_q <= mc_ack_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_inc_i (rst_i && !PCWrite_o),
    .flush_inc_i (taken_flush),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );
`else
  // Flush indication and counter width only feed the counters.
  logic             unused_taken_flush;
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_taken_flush = taken_flush;
  assign unused_cnt_w       = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MC_LAT=4); perf counters checked when
// HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

  // Output vector order: {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EX_hold, mc_done}
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] RSTV = 6'b001100;
  localparam logic [5:0] LU   = 6'b000100;
  localparam logic [5:0] BR   = 6'b111100;
  localparam logic [5:0] MC   = 6'b000010;
  localparam logic [5:0] MCD  = 6'b000011;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       mc;
    logic       br;
    logic [5:0] exp;
  } row_t;

  typedef struct {
    string      name;
    logic [5:0] v;
  } sb_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  ID_rs1_i = '0, ID_rs2_i = '0, EX_rd_i = '0;
  logic        ID_use_rs1_i = 1'b0, ID_use_rs2_i = 1'b0;
  logic        EX_MemRead_i = 1'b0, EX_mc_i = 1'b0, branch_taken_i = 1'b0;
  logic        PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Flush_o, EX_hold_o, mc_done_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int  errors = 0;
  int  checks = 0;
  sb_t sb[$];
  wire [5:0] obs = {PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Flush_o, EX_hold_o, mc_done_o};

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.MC_LAT(4), .CNT_W(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ID_rs1_i       (ID_rs1_i),
    .ID_rs2_i       (ID_rs2_i),
    .ID_use_rs1_i   (ID_use_rs1_i),
    .ID_use_rs2_i   (ID_use_rs2_i),
    .EX_rd_i        (EX_rd_i),
    .EX_MemRead_i   (EX_MemRead_i),
    .EX_mc_i        (EX_mc_i),
    .branch_taken_i (branch_taken_i),
    .PCWrite_o      (PCWrite_o),
    .IFID_Write_o   (IFID_Write_o),
    .IFID_Flush_o   (IFID_Flush_o),
    .IDEX_Flush_o   (IDEX_Flush_o),
    .EX_hold_o      (EX_hold_o),
    .mc_done_o      (mc_done_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  function automatic row_t mk(input string name, input logic rst,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic [4:0] rd, input logic mr,
                              input logic mc, input logic br, input logic [5:0] exp);
    row_t r;
    r.name = name; r.rst = rst; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.rd = rd; r.mr = mr; r.mc = mc; r.br = br; r.exp = exp;
    return r;
  endfunction

  // Drive one cycle of stimulus and record what the outputs must be.
  task automatic drive(input row_t r);
    sb_t e;
    rst_i = r.rst; ID_rs1_i = r.rs1; ID_use_rs1_i = r.u1; ID_rs2_i = r.rs2;
    ID_use_rs2_i = r.u2; EX_rd_i = r.rd; EX_MemRead_i = r.mr; EX_mc_i = r.mc;
    branch_taken_i = r.br;
    e.name = r.name; e.v = r.exp;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    row_t rows[$];
    sb_t  e;
    rows.push_back(mk("reset_c0", 0, 5, 1, 0, 0, 5, 1, 1, 1, RSTV));
    rows.push_back(mk("reset_c1", 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV));
    rows.push_back(mk("reset_rel", 1, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    foreach (rows[i]) begin
      @(posedge clk_i); #1; drive(rows[i]);
      @(negedge clk_i);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs, e.v); end
      else $display("ok   %s: %b", e.name, obs);
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    sb_t  e;
    rows.push_back(mk("lu_rs1",      1, 5, 1, 7, 1, 5, 1, 0, 0, LU));
    rows.push_back(mk("lu_after",    1, 5, 1, 7, 1, 0, 0, 0, 0, NORM));
    rows.push_back(mk("lu_rs2",      1, 3, 1, 9, 1, 9, 1, 0, 0, LU));
    rows.push_back(mk("lu_rs2_aft",  1, 3, 1, 9, 1, 0, 0, 0, 0, NORM));
    foreach (rows[i]) begin
      @(posedge clk_i); #1; drive(rows[i]);
      @(negedge clk_i);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs, e.v); end
      else $display("ok   %s: %b", e.name, obs);
    end
  endtask

  task automatic test_no_false_stall();
    row_t rows[$];
    sb_t  e;
    rows.push_back(mk("nfs_x0",      1, 0, 1, 0, 1, 0, 1, 0, 0, NORM));
    rows.push_back(mk("nfs_unused2", 1, 6, 1, 5, 0, 5, 1, 0, 0, NORM));
    rows.push_back(mk("nfs_unused1", 1, 5, 0, 6, 1, 5, 1, 0, 0, NORM));
    rows.push_back(mk("nfs_alu_rd",  1, 5, 1, 5, 1, 5, 0, 0, 0, NORM));
    foreach (rows[i]) begin
      @(posedge clk_i); #1; drive(rows[i]);
      @(negedge clk_i);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs, e.v); end
      else $display("ok   %s: %b", e.name, obs);
    end
  endtask

  task automatic test_branch_priority();
    row_t rows[$];
    sb_t  e;
    rows.push_back(mk("br_lu",       1, 5, 1, 0, 0, 5, 1, 0, 1, BR));
    rows.push_back(mk("br_lu_next",  1, 8, 1, 0, 0, 0, 0, 0, 0, NORM));
    rows.push_back(mk("br_mc",       1, 0, 0, 0, 0, 0, 0, 1, 1, BR));
    rows.push_back(mk("br_mc_next",  1, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    foreach (rows[i]) begin
      @(posedge clk_i); #1; drive(rows[i]);
      @(negedge clk_i);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs, e.v); end
      else $display("ok   %s: %b", e.name, obs);
    end
  endtask

  task automatic test_multicycle();
    row_t rows[$];
    sb_t  e;
    rows.push_back(mk("mc_t0",        1, 0, 0, 0, 0, 0, 0, 1, 0, MC));
    rows.push_back(mk("mc_t1_br_ign", 1, 5, 1, 0, 0, 5, 1, 0, 1, MC));
    rows.push_back(mk("mc_t2",        1, 0, 0, 0, 0, 0, 0, 1, 0, MC));
    rows.push_back(mk("mc_t3_done",   1, 0, 0, 0, 0, 0, 0, 0, 0, MCD));
    rows.push_back(mk("mc_t4_noretr", 1, 0, 0, 0, 0, 0, 0, 1, 0, NORM));
    rows.push_back(mk("mc_t5",        1, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    foreach (rows[i]) begin
      @(posedge clk_i); #1; drive(rows[i]);
      @(negedge clk_i);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs, e.v); end
      else $display("ok   %s: %b", e.name, obs);
    end
  endtask

  task automatic test_reset_mid_mc();
    row_t rows[$];
    sb_t  e;
    rows.push_back(mk("rmc_t0",     1, 0, 0, 0, 0, 0, 0, 1, 0, MC));
    rows.push_back(mk("rmc_t1_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV));
    rows.push_back(mk("rmc_t2_run", 1, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    rows.push_back(mk("rmc_t3_mc",  1, 0, 0, 0, 0, 0, 0, 1, 0, MC));
    rows.push_back(mk("rmc_t4",     1, 0, 0, 0, 0, 0, 0, 0, 0, MC));
    rows.push_back(mk("rmc_t5",     1, 0, 0, 0, 0, 0, 0, 0, 0, MC));
    rows.push_back(mk("rmc_t6_done",1, 0, 0, 0, 0, 0, 0, 0, 0, MCD));
    rows.push_back(mk("rmc_t7",     1, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    foreach (rows[i]) begin
      @(posedge clk_i); #1; drive(rows[i]);
      @(negedge clk_i);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs, e.v); end
      else $display("ok   %s: %b", e.name, obs);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    sb_t  e;
    rows.push_back(mk("b2b_mc0",     1, 0, 0, 0, 0, 0, 0, 1, 0, MC));
    rows.push_back(mk("b2b_w1",      1, 0, 0, 0, 0, 0, 0, 1, 0, MC));
    rows.push_back(mk("b2b_w2",      1, 0, 0, 0, 0, 0, 0, 1, 0, MC));
    rows.push_back(mk("b2b_done",    1, 0, 0, 0, 0, 0, 0, 1, 0, MCD));
    rows.push_back(mk("b2b_ack_lu",  1, 4, 1, 0, 0, 4, 1, 1, 0, LU));
    rows.push_back(mk("b2b_mc1",     1, 0, 0, 0, 0, 0, 0, 1, 0, MC));
    rows.push_back(mk("b2b_w3",      1, 0, 0, 0, 0, 0, 0, 0, 0, MC));
    rows.push_back(mk("b2b_w4",      1, 0, 0, 0, 0, 0, 0, 0, 0, MC));
    rows.push_back(mk("b2b_done2",   1, 0, 0, 0, 0, 0, 0, 0, 0, MCD));
    rows.push_back(mk("b2b_lu_a",    1, 2, 1, 0, 0, 2, 1, 0, 0, LU));
    rows.push_back(mk("b2b_lu_b",    1, 0, 0, 3, 1, 3, 1, 0, 0, LU));
    rows.push_back(mk("b2b_idle",    1, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    foreach (rows[i]) begin
      @(posedge clk_i); #1; drive(rows[i]);
      @(negedge clk_i);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs, e.v); end
      else $display("ok   %s: %b", e.name, obs);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    row_t rows[$];
    sb_t  e;
    rows.push_back(mk("pc_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV));
    rows.push_back(mk("pc_lu1",  1, 5, 1, 0, 0, 5, 1, 0, 0, LU));
    rows.push_back(mk("pc_n1",   1, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    rows.push_back(mk("pc_lu2",  1, 6, 1, 0, 0, 6, 1, 0, 0, LU));
    rows.push_back(mk("pc_lu3",  1, 0, 0, 7, 1, 7, 1, 0, 0, LU));
    rows.push_back(mk("pc_mc0",  1, 0, 0, 0, 0, 0, 0, 1, 0, MC));
    rows.push_back(mk("pc_mc1",  1, 0, 0, 0, 0, 0, 0, 0, 0, MC));
    rows.push_back(mk("pc_mc2",  1, 0, 0, 0, 0, 0, 0, 0, 0, MC));
    rows.push_back(mk("pc_mc3",  1, 0, 0, 0, 0, 0, 0, 0, 0, MCD));
    rows.push_back(mk("pc_br1",  1, 0, 0, 0, 0, 0, 0, 0, 1, BR));
    rows.push_back(mk("pc_br2",  1, 0, 0, 0, 0, 0, 0, 0, 1, BR));
    foreach (rows[i]) begin
      @(posedge clk_i); #1; drive(rows[i]);
      @(negedge clk_i);
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs, e.v); end
      else $display("ok   %s: %b", e.name, obs);
    end
    @(posedge clk_i); #1; drive(mk("pc_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    @(negedge clk_i);
    e = sb.pop_front();
    checks++;
    if (stall_cnt_o !== 32'd7) begin errors++; $display("FAIL stall_cnt: got %0d want 7", stall_cnt_o); end
    else $display("ok   stall_cnt: %0d", stall_cnt_o);
    checks++;
    if (flush_cnt_o !== 32'd2) begin errors++; $display("FAIL flush_cnt: got %0d want 2", flush_cnt_o); end
    else $display("ok   flush_cnt: %0d", flush_cnt_o);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch_priority();
    test_multicycle();
    test_reset_mid_mc();
    test_back_to_back();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
